// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter feeding a pending-write FIFO that drains onto the RF write port.
// Latency: a transfer into an empty FIFO appears on rf_we/rf_wa/rf_wd in the next cycle.
// Backpressure: src_ready is held at 0 when the FIFO is full, unless the head is popped in the same cycle.
module rf_wb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      src_valid,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic [5*NUM_SRC-1:0]    src_rd,
  input  logic [32*NUM_SRC-1:0]   src_data,
  input  logic                    wb_stall,
  output logic                    rf_we,
  output logic [4:0]              rf_wa,
  output logic [31:0]             rf_wd,
  input  logic [4:0]              fwd_ra1,
  input  logic [4:0]              fwd_ra2,
  output logic                    fwd_hit1,
  output logic                    fwd_hit2,
  output logic [31:0]             fwd_data1,
  output logic [31:0]             fwd_data2,
  output logic                    fifo_full,
  output logic                    fifo_empty
);

  localparam int PW = $clog2(NUM_SRC);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t       mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rr_ptr;

  logic            win_vld;
  logic [PW-1:0]   win_idx;
  logic [4:0]      win_rd;
  logic [31:0]     win_data;
  logic            grant;
  logic            push;
  logic            pop;
  logic [PW-1:0]   next_rr;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign pop        = !fifo_empty && !wb_stall;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign grant      = win_vld && (!fifo_full || pop);
  // x0 results take their arbitration turn but are dropped here.
  assign push       = grant && (win_rd != 5'd0);
  assign next_rr    = (win_idx == PW'(NUM_SRC - 1)) ? '0 : win_idx + PW'(1);

  // Pick the first valid source at or after the round-robin pointer, wrapping to 0.
  always_comb begin
    int cand;
    cand     = 0;
    win_vld  = 1'b0;
    win_idx  = '0;
    win_rd   = '0;
    win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_SRC;
      if (!win_vld && src_valid[cand]) begin
        win_vld  = 1'b1;
        win_idx  = PW'(cand);
        win_rd   = src_rd[5*cand +: 5];
        win_data = src_data[32*cand +: 32];
      end
    end
  end

  // One-hot grant to the winner when the FIFO can take it.
  always_comb begin
    src_ready = '0;
    if (grant) begin
      src_ready = NUM_SRC'(1) << win_idx;
    end
  end

  // Pointer, occupancy and round-robin state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
    end else begin
      if (grant) begin
        rr_ptr <= next_rr;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; validity comes only from the pointers and count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{rd: win_rd, data: win_data};
    end
  end

  // Head entry drives the RF write port whenever it is allowed to leave.
  always_comb begin
    rf_we = pop;
    rf_wa = '0;
    rf_wd = '0;
    if (pop) begin
      rf_wa = mem[rd_ptr].rd;
      rf_wd = mem[rd_ptr].data;
    end
  end

  // Scan oldest to newest so the last match found is the newest pending write.
  function automatic logic [32:0] fwd_lookup(input logic [4:0] ra);
    logic [32:0]   res;
    logic [AW-1:0] idx;
    res = '0;
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      idx = rd_ptr + AW'(j);
      if ((CW'(j) < count) && (ra != 5'd0) && (mem[idx].rd == ra)) begin
        res = {1'b1, mem[idx].data};
      end
    end
    return res;
  endfunction

  // Forwarding for both read ports from the pending entries.
  always_comb begin
    {fwd_hit1, fwd_data1} = fwd_lookup(fwd_ra1);
    {fwd_hit2, fwd_data2} = fwd_lookup(fwd_ra2);
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios then randomized traffic against a queue model.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Sources hold their request until granted, as the interface requires.
module tb_rf_wb_arbiter;
  localparam int N = 4;
  localparam int D = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [5*N-1:0]  src_rd;
  logic [32*N-1:0] src_data;
  logic            wb_stall = 1'b0;
  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [31:0]     rf_wd;
  logic [4:0]      fwd_ra1 = '0;
  logic [4:0]      fwd_ra2 = '0;
  logic            fwd_hit1, fwd_hit2;
  logic [31:0]     fwd_data1, fwd_data2;
  logic            fifo_full, fifo_empty;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready), .src_rd(src_rd), .src_data(src_data),
    .wb_stall(wb_stall), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .fwd_ra1(fwd_ra1), .fwd_ra2(fwd_ra2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  // Reference model: ordered list of pending writes plus the next-turn source.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  ent_t q[$];
  int   rr = 0;

  // Per-source requests, held until granted.
  bit          req_v [N];
  logic [4:0]  req_rd[N];
  logic [31:0] req_d [N];
  bit          auto_retire = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] obs_ready;
  logic         obs_we, obs_full, obs_empty, obs_hit1, obs_hit2;
  logic [4:0]   obs_wa;
  logic [31:0]  obs_wd, obs_d1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model_fwd(input logic [4:0] ra);
    for (int j = q.size() - 1; j >= 0; j--) begin
      if (ra != 5'd0 && q[j].rd == ra) return {1'b1, q[j].data};
    end
    return 33'd0;
  endfunction

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      src_valid[s]         = req_v[s];
      src_rd[5*s +: 5]     = req_rd[s];
      src_data[32*s +: 32] = req_d[s];
    end
  endtask

  task automatic clear_reqs();
    for (int s = 0; s < N; s++) begin
      req_v[s]  = 1'b0;
      req_rd[s] = '0;
      req_d[s]  = '0;
    end
  endtask

  task automatic arm(input int s, input logic [4:0] rd, input logic [31:0] d);
    req_v[s]  = 1'b1;
    req_rd[s] = rd;
    req_d[s]  = d;
  endtask

  // One clock: drive, check every output against the model at negedge, advance the model at posedge.
  task automatic cycle();
    int           k;
    bit           pop;
    logic [N-1:0] er;
    logic [32:0]  f1, f2;
    drive();
    @(negedge clk);
    obs_ready = src_ready; obs_we = rf_we; obs_wa = rf_wa; obs_wd = rf_wd;
    obs_full = fifo_full; obs_empty = fifo_empty;
    obs_hit1 = fwd_hit1; obs_d1 = fwd_data1; obs_hit2 = fwd_hit2;
    k   = -1;
    pop = 1'b0;
    if (!rst) begin
      check("reset_rf_we", 32'(rf_we), 32'd0);
      check("reset_rf_wa", 32'(rf_wa), 32'd0);
      check("reset_rf_wd", rf_wd, 32'd0);
      check("reset_empty", 32'(fifo_empty), 32'd1);
      check("reset_full", 32'(fifo_full), 32'd0);
      check("reset_hit1", 32'(fwd_hit1), 32'd0);
      check("reset_hit2", 32'(fwd_hit2), 32'd0);
      check("reset_fdata1", fwd_data1, 32'd0);
      check("reset_fdata2", fwd_data2, 32'd0);
    end else begin
      pop = (q.size() > 0) && !wb_stall;
      if (q.size() < D || pop) begin
        for (int i = 0; i < N; i++) begin
          if (k < 0 && req_v[(rr + i) % N]) k = (rr + i) % N;
        end
      end
      er = '0;
      if (k >= 0) er[k] = 1'b1;
      f1 = model_fwd(fwd_ra1);
      f2 = model_fwd(fwd_ra2);
      check("src_ready", 32'(src_ready), 32'(er));
      check("rf_we", 32'(rf_we), 32'(pop));
      check("rf_wa", 32'(rf_wa), pop ? 32'(q[0].rd) : 32'd0);
      check("rf_wd", rf_wd, pop ? q[0].data : 32'd0);
      check("fifo_full", 32'(fifo_full), 32'(q.size() == D));
      check("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
      check("fwd_hit1", 32'(fwd_hit1), 32'(f1[32]));
      check("fwd_data1", fwd_data1, f1[31:0]);
      check("fwd_hit2", 32'(fwd_hit2), 32'(f2[32]));
      check("fwd_data2", fwd_data2, f2[31:0]);
    end
    @(posedge clk);
    if (rst) begin
      if (pop) void'(q.pop_front());
      if (k >= 0) begin
        rr = (k + 1) % N;
        if (req_rd[k] != 5'd0) q.push_back('{rd: req_rd[k], data: req_d[k]});
      end
    end
    #1;
    if (k >= 0 && auto_retire) req_v[k] = 1'b0;
  endtask

  initial begin
    int nwe;
    clear_reqs();
    drive();
    cycle();
    cycle();
    rst = 1'b1;

    // Round-robin with all sources held valid.
    auto_retire = 1'b0;
    for (int s = 0; s < N; s++) arm(s, 5'(s + 1), 32'hA000_0000 + 32'(s));
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rr_grant", 32'(obs_ready), 32'(1) << (i % 4));
      if (i > 0) begin
        check("rr_we", 32'(obs_we), 32'd1);
        check("rr_wa", 32'(obs_wa), 32'(i));
      end
    end
    auto_retire = 1'b1;
    clear_reqs();
    repeat (3) cycle();

    // Single write from source 1.
    arm(1, 5'd5, 32'hDEAD_BEEF);
    cycle();
    check("single_grant", 32'(obs_ready), 32'b0010);
    cycle();
    check("single_we", 32'(obs_we), 32'd1);
    check("single_wa", 32'(obs_wa), 32'd5);
    check("single_wd", obs_wd, 32'hDEAD_BEEF);
    cycle();
    check("single_idle_we", 32'(obs_we), 32'd0);
    check("single_empty", 32'(obs_empty), 32'd1);

    // Fill under stall, then release with a simultaneous push and pop.
    wb_stall = 1'b1;
    for (int s = 0; s < N; s++) arm(s, 5'(8 + s), 32'hB000_0000 + 32'(s));
    repeat (4) cycle();
    arm(0, 5'd12, 32'hB000_00FF);
    cycle();
    check("full_flag", 32'(obs_full), 32'd1);
    check("full_ready", 32'(obs_ready), 32'd0);
    wb_stall = 1'b0;
    cycle();
    check("release_grant", 32'(obs_ready), 32'b0001);
    check("release_we", 32'(obs_we), 32'd1);
    check("release_wa", 32'(obs_wa), 32'd10);
    repeat (6) cycle();

    // Forwarding picks the newer of two writes to the same register; x0 is never written.
    wb_stall = 1'b1;
    arm(2, 5'd7, 32'h11);
    cycle();
    arm(2, 5'd7, 32'h22);
    cycle();
    fwd_ra1 = 5'd7;
    fwd_ra2 = 5'd0;
    arm(3, 5'd0, 32'h55);
    cycle();
    check("fwd_hit1", 32'(obs_hit1), 32'd1);
    check("fwd_newest", obs_d1, 32'h22);
    check("fwd_x0_miss", 32'(obs_hit2), 32'd0);
    check("x0_grant", 32'(obs_ready), 32'b1000);
    wb_stall = 1'b0;
    nwe = 0;
    repeat (4) begin
      cycle();
      if (obs_we) nwe++;
    end
    check("x0_drain_writes", 32'(nwe), 32'd2);

    // Reset in the middle of traffic with three entries queued.
    wb_stall = 1'b1;
    arm(0, 5'd3, 32'h33);
    arm(1, 5'd4, 32'h44);
    arm(2, 5'd5, 32'h55);
    repeat (3) cycle();
    fwd_ra1 = 5'd4;
    fwd_ra2 = 5'd3;
    clear_reqs();
    rst = 1'b0;
    q.delete();
    rr = 0;
    cycle();
    check("midrst_empty", 32'(obs_empty), 32'd1);
    rst = 1'b1;
    wb_stall = 1'b0;
    for (int s = 0; s < N; s++) arm(s, 5'(20 + s), 32'hC000_0000 + 32'(s));
    cycle();
    check("postrst_we", 32'(obs_we), 32'd0);
    check("postrst_rr", 32'(obs_ready), 32'b0001);
    repeat (6) cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      wb_stall = ($urandom_range(3) == 0);
      fwd_ra1  = 5'($urandom_range(7));
      fwd_ra2  = 5'($urandom_range(7));
      for (int s = 0; s < N; s++) begin
        if (!req_v[s] && $urandom_range(1) == 1) arm(s, 5'($urandom_range(7)), $urandom);
      end
      cycle();
    end
    clear_reqs();
    wb_stall = 1'b0;
    repeat (6) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
